// File: rtl/lz77_decoder.sv
// LZ77 token decoder: rebuilds the byte stream from (offset, length, literal) tokens using
// a 2**OFF_W circular history. Define LZ77_DEC_CHECK_EN to flag and neutralise bad offsets.
module lz77_decoder #(
  parameter int DATA_W = 8,
  parameter int OFF_W  = 6,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [OFF_W-1:0]  tok_offset,
  input  logic [LEN_W-1:0]  tok_length,
  input  logic [DATA_W-1:0] tok_literal,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              err
);
  localparam int DEPTH = 1 << OFF_W;

  typedef enum logic [1:0] {IDLE = 2'd0, COPY = 2'd1, LIT = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [OFF_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   lit_q, lit_d;
  logic                tok_ready_q, tok_ready_d, out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   hist [DEPTH];
  logic                accept, xfer, bad_tok;

  assign accept    = tok_valid & tok_ready_q;
  assign xfer      = out_valid_q & out_ready;
  assign tok_ready = tok_ready_q;
  assign out_valid = out_valid_q;
  // Copy bytes read the RAM combinationally so a byte written last cycle is visible now.
  assign out_data  = (state_q == LIT) ? lit_q : hist[rd_ptr_q];

`ifdef LZ77_DEC_CHECK_EN
  localparam logic [OFF_W:0] FULL = (OFF_W + 1)'(DEPTH);
  logic [OFF_W:0] fill_q, fill_d;
  logic           err_q, err_d;

  assign bad_tok = (tok_length != '0) &&
                   ((tok_offset == '0) || ({1'b0, tok_offset} > fill_q));
  assign err     = err_q;

  always_comb begin
    fill_d = fill_q;
    err_d  = err_q;
    if (xfer && fill_q != FULL) fill_d = fill_q + 1'b1;
    if (accept && bad_tok)      err_d  = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= '0;
      err_q  <= 1'b0;
    end else begin
      fill_q <= fill_d;
      err_q  <= err_d;
    end
  end
`else
  assign bad_tok = 1'b0;
  assign err     = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    lit_d    = lit_q;
    case (state_q)
      IDLE: if (accept) begin
        lit_d    = tok_literal;
        rd_ptr_d = wr_ptr_q - tok_offset;
        if (bad_tok) begin
          cnt_d   = '0;
          state_d = LIT;
        end else begin
          cnt_d   = tok_length;
          state_d = (tok_length != '0) ? COPY : LIT;
        end
      end
      COPY: if (xfer) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == LEN_W'(1)) state_d = LIT;
      end
      LIT: if (xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (xfer) wr_ptr_d = wr_ptr_q + 1'b1;
    tok_ready_d = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      lit_q       <= '0;
      tok_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      lit_q       <= lit_d;
      tok_ready_q <= tok_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // History survives reset on purpose.
  always_ff @(posedge clk) begin
    if (xfer) hist[wr_ptr_q] <= out_data;
  end
endmodule

// File: tb/tb_lz77_decoder.sv
// Self-checking bench for lz77_decoder: directed token scenarios plus a randomized run
// against a byte-level LZ77 history model.
module tb_lz77_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tok_valid = 1'b0, tok_ready;
  logic [5:0] tok_offset = '0;
  logic [3:0] tok_length = '0;
  logic [7:0] tok_literal = '0;
  logic       out_valid, out_ready = 1'b0;
  logic [7:0] out_data;
  logic       err;

  int total = 0, bad = 0;

  lz77_decoder #(.DATA_W(8), .OFF_W(6), .LEN_W(4)) dut (
    .clk(clk), .rst(rst), .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_offset(tok_offset), .tok_length(tok_length), .tok_literal(tok_literal),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: history as plain array, -1 = never written.
  int m_hist [64];
  int m_wp = 0, m_fill = 0;
  bit m_err = 0;
  int exp_q [$];
  logic [7:0] got_q [$];
  logic [9:0] stall_q [$];
  int first_beat, to_cnt = 0;

  task automatic m_put(input int b);
    exp_q.push_back(b);
    m_hist[m_wp] = b;
    m_wp = (m_wp + 1) % 64;
    if (m_fill < 64) m_fill++;
  endtask

  task automatic model_tok(input int off, input int len, input int lit);
    int n = len;
    exp_q.delete();
`ifdef LZ77_DEC_CHECK_EN
    if (len != 0 && (off == 0 || off > m_fill)) begin n = 0; m_err = 1; end
`endif
    for (int i = 0; i < n; i++) m_put(m_hist[(m_wp - off) & 63]);
    m_put(lit);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    m_wp = 0; m_fill = 0; m_err = 0;
  endtask

  // Drives one token and collects nexp beats; optional 3-cycle stall after beat stall_at.
  task automatic send_tok(input int off, input int len, input int lit, input int pct,
                          input int stall_at, input int nexp);
    int n = 0, stall_cnt = 0;
    got_q.delete(); stall_q.delete(); first_beat = -1;
    @(negedge clk);
    tok_offset = 6'(off); tok_length = 4'(len); tok_literal = 8'(lit); tok_valid = 1'b1;
    while (!tok_ready && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    tok_valid = 1'b0; tok_offset = 6'($urandom); tok_length = 4'($urandom); tok_literal = 8'($urandom);
    n = 0;
    while (got_q.size() < nexp && n < 300) begin
      @(negedge clk); n++;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_q.push_back({tok_ready, out_valid, out_data});
        stall_cnt--;
      end else out_ready = ($urandom_range(99) < pct);
      if (out_valid && out_ready) begin
        if (first_beat < 0) first_beat = n;
        got_q.push_back(out_data);
        if (got_q.size() == stall_at) stall_cnt = 3;
      end
    end
    if (got_q.size() < nexp) to_cnt++;
  endtask

  task automatic xact(input int off, input int len, input int lit, input int pct, input int stall_at);
    model_tok(off, len, lit);
    send_tok(off, len, lit, pct, stall_at, exp_q.size());
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (tok_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
      bad++; $display("FAIL reset_outputs got rdy=%b vld=%b err=%b need 0 0 0", tok_ready, out_valid, err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (tok_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b need=1", tok_ready); end
  endtask

  task automatic test_literal();
    xact(0, 0, 8'h41, 100, 0);
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h41) begin
      bad++; $display("FAIL literal_byte got n=%0d b=%02h need n=1 b=41", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
    total++;
    if (first_beat != 1) begin bad++; $display("FAIL literal_latency got=%0d need=1", first_beat); end
    @(negedge clk);
    total++;
    if (tok_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL literal_ready_back got rdy=%b vld=%b need 1 0", tok_ready, out_valid);
    end
  endtask

  task automatic test_copy();
    logic [7:0] e [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    xact(0, 0, 8'h41, 100, 0);
    xact(0, 0, 8'h42, 100, 0);
    xact(0, 0, 8'h43, 100, 0);
    xact(3, 3, 8'h44, 100, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== e[i]) begin
        bad++; $display("FAIL copy_beat%0d got=%02h need=%02h", i, got_q.size() > i ? got_q[i] : 8'h00, e[i]);
      end
    end
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL copy_err got=%b need=0", err); end
  endtask

  task automatic test_overlap();
    logic [7:0] e [5] = '{8'h58, 8'h58, 8'h58, 8'h58, 8'h59};
    xact(0, 0, 8'h58, 100, 0);
    xact(1, 4, 8'h59, 70, 0);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== e[i]) begin
        bad++; $display("FAIL overlap_beat%0d got=%02h need=%02h", i, got_q.size() > i ? got_q[i] : 8'h00, e[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] e [4] = '{8'h41, 8'h42, 8'h43, 8'h44};
    int n = 0;
    do_reset();
    xact(0, 0, 8'h41, 100, 0);
    xact(0, 0, 8'h42, 100, 0);
    xact(0, 0, 8'h43, 100, 0);
    xact(3, 3, 8'h44, 100, 1);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== e[i]) begin
        bad++; $display("FAIL bp_beat%0d got=%02h need=%02h", i, got_q.size() > i ? got_q[i] : 8'h00, e[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (stall_q.size() <= i || stall_q[i] !== {2'b01, 8'h42}) begin
        bad++; $display("FAIL bp_hold%0d got=%03h need=142", i, stall_q.size() > i ? stall_q[i] : 10'h0);
      end
    end
    // Reset in the middle of a stalled copy token.
    @(negedge clk);
    out_ready = 1'b0;
    tok_offset = 6'd3; tok_length = 4'd3; tok_literal = 8'h44; tok_valid = 1'b1;
    while (!tok_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1 tok_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_pre got vld=%b need=1", out_valid); end
    rst = 1'b1; #1;
    total++;
    if (out_valid !== 1'b0 || tok_ready !== 1'b0) begin
      bad++; $display("FAIL midrst_async got vld=%b rdy=%b need 0 0", out_valid, tok_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_wp = 0; m_fill = 0; m_err = 0;
    xact(0, 0, 8'h61, 100, 0);
    xact(1, 2, 8'h62, 100, 0);
    total++;
    if (got_q.size() != 3 || got_q[0] !== 8'h61 || got_q[1] !== 8'h61 || got_q[2] !== 8'h62) begin
      bad++; $display("FAIL midrst_after got n=%0d b0=%02h need 61 61 62", got_q.size(), got_q.size() ? got_q[0] : 8'h00);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] e [3] = '{8'h07, 8'h08, 8'hFF};
    do_reset();
    for (int i = 0; i < 70; i++) xact(0, 0, i, 100, 0);
    xact(63, 2, 8'hFF, 100, 0);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== e[i]) begin
        bad++; $display("FAIL wrap_beat%0d got=%02h need=%02h", i, got_q.size() > i ? got_q[i] : 8'h00, e[i]);
      end
    end
  endtask

  task automatic test_invalid();
    do_reset();
    xact(5, 2, 8'h5A, 100, 0);
`ifdef LZ77_DEC_CHECK_EN
    total++;
    if (got_q.size() != 1 || got_q[0] !== 8'h5A || err !== 1'b1) begin
      bad++; $display("FAIL invalid_chk got n=%0d err=%b need n=1 b=5A err=1", got_q.size(), err);
    end
`else
    total++;
    if (got_q.size() != 3 || got_q[2] !== 8'h5A || err !== 1'b0) begin
      bad++; $display("FAIL invalid_nochk got n=%0d err=%b need n=3 last=5A err=0", got_q.size(), err);
    end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (got_q.size() <= i || got_q[i] !== 8'(exp_q[i])) begin
        bad++; $display("FAIL invalid_hist%0d got=%02h need=%02h", i, got_q.size() > i ? got_q[i] : 8'h00, 8'(exp_q[i]));
      end
    end
`endif
  endtask

  task automatic test_random();
    int errs = 0;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      int off = $urandom_range(63);
      int len = $urandom_range(15);
      if (m_fill > 0 && $urandom_range(3) != 0) off = $urandom_range((m_fill > 63) ? 63 : m_fill, 1);
      xact(off, len, $urandom_range(255), 60, 0);
      for (int i = 0; i < exp_q.size(); i++) begin
        if (exp_q[i] >= 0) begin
          total++;
          if (got_q.size() <= i || got_q[i] !== 8'(exp_q[i])) begin
            bad++; errs++;
            if (errs < 10) $display("FAIL rand_t%0d_b%0d got=%02h need=%02h", t, i,
                                    got_q.size() > i ? got_q[i] : 8'h00, 8'(exp_q[i]));
          end
        end
      end
      total++;
      if (err !== m_err) begin bad++; $display("FAIL rand_err_t%0d got=%b need=%b", t, err, m_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_hist[i] = -1;
    test_reset();
    test_literal();
    test_copy();
    test_overlap();
    test_backpressure();
    test_wrap();
    test_invalid();
    test_random();
    total++;
    if (to_cnt != 0) begin bad++; $display("FAIL beat_timeout got=%0d need=0", to_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
